tap_top: RTL and testbench
==========================

TAP_TOP -- requirements
Module: tap_top

Interface
REQ-001 SHALL provide: tck_i  in  1  sole clock (JTAG TCK); all state changes on its rising edge except td_o.
REQ-002 SHALL provide: rst_ni  in  1  reset; one clock, reset is asynchronous and active-high (rst_ni=1 resets).
REQ-003 SHALL provide: tms_i in 1 mode select; td_i in 1 serial data in; td_o out 1 serial data out.
REQ-004 SHALL provide: shift_dr_o, update_dr_o, capture_dr_o  out  1  high while FSM is in Shift-DR, Update-DR or Capture-DR.
REQ-005 SHALL provide: memory_sel_o, fifo_sel_o, confreg_sel_o, clk_byp_sel_o, observ_sel_o, pmu_sel_o  out  1  decoded IR selects.
REQ-006 SHALL provide: scan_in_o  out  1  equals td_i, fanned out to sub-module chains.
REQ-007 SHALL provide: pmu_tdi_o, pmu_tck_o, pmu_rst_o, pmu_en_o  out  1  PMU scan port.
REQ-008 SHALL provide: memory_out_i, fifo_out_i, confreg_out_i, clk_byp_out_i, observ_out_i, pmu_tdo_i  in  1  return data from sub-chains.

Function
REQ-009 SHALL implement the 16-state IEEE 1149.1 TAP FSM (Test-Logic-Reset, Run-Test/Idle, Select/Capture/Shift/Exit1/Pause/Exit2/Update for DR and IR) with standard TMS transitions.
REQ-010 Five consecutive TMS=1 clocks SHALL reach Test-Logic-Reset from any state.
REQ-011 IR SHALL be 5 bits, shifted LSB first from td_i in Shift-IR, including the Shift-IR cycle that exits with TMS=1; Capture-IR loads 5'b00001.
REQ-012 Active IR SHALL update only in Update-IR; in Test-Logic-Reset it SHALL be IDCODE.
REQ-013 Opcodes: IDCODE 00010, REG1 00100, REG2 00101, REG3 00110, REG_CLK_BYP 00111, REG_OBSERV 01000, REG6 01001, PMU_WO_CS 11010, PMU_W_CS 11011, BYPASS 11111; any other opcode SHALL act as BYPASS.
REQ-014 IDCODE SHALL be a 32-bit register capturing 32'h1000_0001 in Capture-DR and shifting LSB first.
REQ-015 BYPASS SHALL be 1 bit, capturing 0 in Capture-DR.
REQ-016 Selects: REG1->memory_sel_o, REG2->fifo_sel_o, REG3->confreg_sel_o, REG_CLK_BYP->clk_byp_sel_o, REG_OBSERV->observ_sel_o, PMU_W_CS/PMU_WO_CS->pmu_sel_o; at most one high; REG6 asserts none and uses bypass.
REQ-017 td_o SHALL update on tck_i falling edge: IR LSB in Shift-IR; in Shift-DR the selected source (IDCODE LSB, bypass bit, *_out_i, or pmu_tdo_i); otherwise 0.
REQ-018 pmu_tdi_o SHALL equal td_i; pmu_tck_o SHALL equal tck_i gated so it toggles only while pmu_sel_o=1 and the FSM is in Shift-DR, else low.
REQ-019 pmu_en_o SHALL be 1 only while IR=PMU_W_CS and FSM is in Shift-DR; 0 for PMU_WO_CS.
REQ-020 pmu_rst_o SHALL be 1 while the FSM is in Test-Logic-Reset or rst_ni=1, else 0.
REQ-021 Gating cell SHALL be glitch-free (latch-based enable, low-phase latch).

Reset
REQ-022 On rst_ni=1: FSM Test-Logic-Reset, IR=IDCODE, IR/DR shift registers cleared, bypass=0, td_o=0, all strobes/selects 0, pmu_en_o=0, pmu_tck_o=0, pmu_rst_o=1.
REQ-023 Reset asserted mid-shift SHALL abort immediately; no partial IR update.

Structure
REQ-024 Package tap_pkg SHALL hold the FSM state enum, IR width (5), all opcode constants and the IDCODE value.
REQ-025 The FSM SHALL be sub-module tap_fsm (inputs tck_i, rst_ni, tms_i; outputs state); tap_top holds IR, DR, muxing and PMU gating.

Verification
REQ-026 Reset pulse then TMS 0,1,1,0,0 and 5 Shift-IR bits 1,1,0,1,1 (last with TMS=1), TMS=1 -> Update-IR; IR=11011, pmu_sel_o=1.
REQ-027 After REQ-026, Capture-DR plus 64 Shift-DR clocks with td_i=1 -> pmu_en_o=1, pmu_tdi_o=1, 64 pmu_tck_o pulses, td_o follows pmu_tdo_i; TMS 11111 -> Test-Logic-Reset, pmu_rst_o=1.
REQ-028 After reset, shift 32 DR bits -> td_o yields 32'h1000_0001 LSB first.
REQ-029 IR=BYPASS, shift 8'hA5 -> td_o yields 0 then 8'hA5 delayed one clock.
REQ-030 IR=PMU_WO_CS, shift DR -> pmu_en_o stays 0, pmu_tck_o toggles; IR=REG2 -> fifo_sel_o=1, td_o tracks fifo_out_i.
REQ-031 Assert rst_ni in Shift-IR -> FSM Test-Logic-Reset, IR=IDCODE, all selects 0 immediately.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared types, opcodes and constants for the JTAG TAP controller.
package tap_pkg;

  localparam int unsigned IrWidth = 5;
  localparam logic [31:0] IdcodeValue = 32'h1000_0001;
  localparam logic [IrWidth-1:0] IrCapture = 5'b00001;

  localparam logic [IrWidth-1:0] OpIdcode    = 5'b00010;
  localparam logic [IrWidth-1:0] OpReg1      = 5'b00100;
  localparam logic [IrWidth-1:0] OpReg2      = 5'b00101;
  localparam logic [IrWidth-1:0] OpReg3      = 5'b00110;
  localparam logic [IrWidth-1:0] OpRegClkByp = 5'b00111;
  localparam logic [IrWidth-1:0] OpRegObserv = 5'b01000;
  localparam logic [IrWidth-1:0] OpReg6      = 5'b01001;
  localparam logic [IrWidth-1:0] OpPmuWoCs   = 5'b11010;
  localparam logic [IrWidth-1:0] OpPmuWCs    = 5'b11011;
  localparam logic [IrWidth-1:0] OpBypass    = 5'b11111;

  typedef enum logic [3:0] {
    TestLogicReset,
    RunTestIdle,
    SelectDrScan,
    CaptureDr,
    ShiftDr,
    Exit1Dr,
    PauseDr,
    Exit2Dr,
    UpdateDr,
    SelectIrScan,
    CaptureIr,
    ShiftIr,
    Exit1Ir,
    PauseIr,
    Exit2Ir,
    UpdateIr
  } tap_state_e;

  // Which data register feeds td_o during Shift-DR.
  typedef enum logic [2:0] {
    SrcIdcode,
    SrcBypass,
    SrcMemory,
    SrcFifo,
    SrcConfreg,
    SrcClkByp,
    SrcObserv,
    SrcPmu
  } tap_src_e;

  function automatic tap_src_e decode_src(logic [IrWidth-1:0] ir);
    case (ir)
      OpIdcode:              return SrcIdcode;
      OpReg1:                return SrcMemory;
      OpReg2:                return SrcFifo;
      OpReg3:                return SrcConfreg;
      OpRegClkByp:           return SrcClkByp;
      OpRegObserv:           return SrcObserv;
      OpPmuWoCs, OpPmuWCs:   return SrcPmu;
      default:               return SrcBypass;
    endcase
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// IEEE 1149.1 16-state TAP controller state machine.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       tck_i,
  input  logic       rst_ni,
  input  logic       tms_i,
  output tap_state_e state_o
);

  always_ff @(posedge tck_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_o <= TestLogicReset;
    end else begin
      unique case (state_o)
        TestLogicReset: state_o <= tms_i ? TestLogicReset : RunTestIdle;
        RunTestIdle:    state_o <= tms_i ? SelectDrScan   : RunTestIdle;
        SelectDrScan:   state_o <= tms_i ? SelectIrScan   : CaptureDr;
        CaptureDr:      state_o <= tms_i ? Exit1Dr        : ShiftDr;
        ShiftDr:        state_o <= tms_i ? Exit1Dr        : ShiftDr;
        Exit1Dr:        state_o <= tms_i ? UpdateDr       : PauseDr;
        PauseDr:        state_o <= tms_i ? Exit2Dr        : PauseDr;
        Exit2Dr:        state_o <= tms_i ? UpdateDr       : ShiftDr;
        UpdateDr:       state_o <= tms_i ? SelectDrScan   : RunTestIdle;
        SelectIrScan:   state_o <= tms_i ? TestLogicReset : CaptureIr;
        CaptureIr:      state_o <= tms_i ? Exit1Ir        : ShiftIr;
        ShiftIr:        state_o <= tms_i ? Exit1Ir        : ShiftIr;
        Exit1Ir:        state_o <= tms_i ? UpdateIr       : PauseIr;
        PauseIr:        state_o <= tms_i ? Exit2Ir        : PauseIr;
        Exit2Ir:        state_o <= tms_i ? UpdateIr       : ShiftIr;
        UpdateIr:       state_o <= tms_i ? SelectDrScan   : RunTestIdle;
        default:        state_o <= TestLogicReset;
      endcase
    end
  end

endmodule

// File: rtl/tap_top.sv
// JTAG TAP: instruction/data registers, sub-chain selects, td_o mux and PMU scan port.
module tap_top
  import tap_pkg::*;
(
  input  logic tck_i,
  input  logic rst_ni,
  input  logic tms_i,
  input  logic td_i,
  output logic td_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic capture_dr_o,
  output logic memory_sel_o,
  output logic fifo_sel_o,
  output logic confreg_sel_o,
  output logic clk_byp_sel_o,
  output logic observ_sel_o,
  output logic pmu_sel_o,
  output logic scan_in_o,
  output logic pmu_tdi_o,
  output logic pmu_tck_o,
  output logic pmu_rst_o,
  output logic pmu_en_o,
  input  logic memory_out_i,
  input  logic fifo_out_i,
  input  logic confreg_out_i,
  input  logic clk_byp_out_i,
  input  logic observ_out_i,
  input  logic pmu_tdo_i
);

  tap_state_e         state;
  logic [IrWidth-1:0] ir_shift_q;
  logic [IrWidth-1:0] ir_q;
  logic [IrWidth-1:0] ir_active;
  logic [31:0]        idcode_q;
  logic               bypass_q;
  logic               td_q;
  logic               dr_tdo;
  logic               gate_en;
  tap_src_e           src;

  tap_fsm u_fsm (
    .tck_i   (tck_i),
    .rst_ni  (rst_ni),
    .tms_i   (tms_i),
    .state_o (state)
  );

  always_ff @(posedge tck_i or posedge rst_ni) begin
    if (rst_ni) begin
      ir_shift_q <= '0;
      ir_q       <= OpIdcode;
      idcode_q   <= '0;
      bypass_q   <= 1'b0;
    end else begin
      case (state)
        TestLogicReset: ir_q <= OpIdcode;
        CaptureIr:      ir_shift_q <= IrCapture;
        ShiftIr:        ir_shift_q <= {td_i, ir_shift_q[IrWidth-1:1]};
        UpdateIr:       ir_q <= ir_shift_q;
        CaptureDr: begin
          idcode_q <= IdcodeValue;
          bypass_q <= 1'b0;
        end
        ShiftDr: begin
          idcode_q <= {td_i, idcode_q[31:1]};
          bypass_q <= td_i;
        end
        default: ;
      endcase
    end
  end

  // The register only reloads on the edge leaving Test-Logic-Reset, so force IDCODE while there.
  assign ir_active = (state == TestLogicReset) ? OpIdcode : ir_q;
  assign src       = decode_src(ir_active);

  assign memory_sel_o  = (src == SrcMemory);
  assign fifo_sel_o    = (src == SrcFifo);
  assign confreg_sel_o = (src == SrcConfreg);
  assign clk_byp_sel_o = (src == SrcClkByp);
  assign observ_sel_o  = (src == SrcObserv);
  assign pmu_sel_o     = (src == SrcPmu);

  assign shift_dr_o   = (state == ShiftDr);
  assign update_dr_o  = (state == UpdateDr);
  assign capture_dr_o = (state == CaptureDr);

  always_comb begin
    dr_tdo = bypass_q;
    case (src)
      SrcIdcode:  dr_tdo = idcode_q[0];
      SrcMemory:  dr_tdo = memory_out_i;
      SrcFifo:    dr_tdo = fifo_out_i;
      SrcConfreg: dr_tdo = confreg_out_i;
      SrcClkByp:  dr_tdo = clk_byp_out_i;
      SrcObserv:  dr_tdo = observ_out_i;
      SrcPmu:     dr_tdo = pmu_tdo_i;
      default:    dr_tdo = bypass_q;
    endcase
  end

  always_ff @(negedge tck_i or posedge rst_ni) begin
    if (rst_ni) begin
      td_q <= 1'b0;
    end else begin
      case (state)
        ShiftIr: td_q <= ir_shift_q[0];
        ShiftDr: td_q <= dr_tdo;
        default: td_q <= 1'b0;
      endcase
    end
  end

  assign td_o      = td_q;
  assign scan_in_o = td_i;
  assign pmu_tdi_o = td_i;

  // Low-phase latch: enable can only change while tck is low, so the gated clock never glitches.
  always_latch begin
    if (rst_ni) begin
      gate_en <= 1'b0;
    end else if (!tck_i) begin
      gate_en <= pmu_sel_o && (state == ShiftDr);
    end
  end

  assign pmu_tck_o = tck_i & gate_en;
  assign pmu_en_o  = (ir_active == OpPmuWCs) && (state == ShiftDr);
  assign pmu_rst_o = rst_ni | (state == TestLogicReset);

endmodule

// File: tb/tb_tap_top.sv
// Self-checking bench for tap_top: vector table over all opcodes, directed scans, random scans.
module tb_tap_top;

  logic tck_i, rst_ni, tms_i, td_i;
  logic td_o, shift_dr_o, update_dr_o, capture_dr_o;
  logic memory_sel_o, fifo_sel_o, confreg_sel_o, clk_byp_sel_o, observ_sel_o, pmu_sel_o;
  logic scan_in_o, pmu_tdi_o, pmu_tck_o, pmu_rst_o, pmu_en_o;
  logic memory_out_i, fifo_out_i, confreg_out_i, clk_byp_out_i, observ_out_i, pmu_tdo_i;

  tap_top dut (
    .tck_i         (tck_i),
    .rst_ni        (rst_ni),
    .tms_i         (tms_i),
    .td_i          (td_i),
    .td_o          (td_o),
    .shift_dr_o    (shift_dr_o),
    .update_dr_o   (update_dr_o),
    .capture_dr_o  (capture_dr_o),
    .memory_sel_o  (memory_sel_o),
    .fifo_sel_o    (fifo_sel_o),
    .confreg_sel_o (confreg_sel_o),
    .clk_byp_sel_o (clk_byp_sel_o),
    .observ_sel_o  (observ_sel_o),
    .pmu_sel_o     (pmu_sel_o),
    .scan_in_o     (scan_in_o),
    .pmu_tdi_o     (pmu_tdi_o),
    .pmu_tck_o     (pmu_tck_o),
    .pmu_rst_o     (pmu_rst_o),
    .pmu_en_o      (pmu_en_o),
    .memory_out_i  (memory_out_i),
    .fifo_out_i    (fifo_out_i),
    .confreg_out_i (confreg_out_i),
    .clk_byp_out_i (clk_byp_out_i),
    .observ_out_i  (observ_out_i),
    .pmu_tdo_i     (pmu_tdo_i)
  );

  initial tck_i = 1'b0;
  always #5 tck_i = ~tck_i;

  // src: 0 idcode, 1 bypass, 2 memory, 3 fifo, 4 confreg, 5 clk_byp, 6 observ, 7 pmu
  typedef struct {
    logic [4:0]  op;
    logic [5:0]  sel;  // {memory, fifo, confreg, clk_byp, observ, pmu}
    int unsigned src;
    logic        en;
  } vec_t;

  vec_t        tbl[10];
  vec_t        cur;
  int          n_cmp, n_bad;
  int          pulses;
  logic [5:0]  sels;
  logic [31:0] idcode_ref;
  logic [63:0] r;
  logic        s_tdo, s_cap, s_upd, s_shift, s_en, s_ptdi, s_scan;

  assign sels = {memory_sel_o, fifo_sel_o, confreg_sel_o, clk_byp_sel_o, observ_sel_o, pmu_sel_o};

  initial pulses = 0;
  always @(posedge pmu_tck_o) pulses = pulses + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t lookup(input logic [4:0] op);
    vec_t v;
    v = '{op, 6'b000000, 1, 1'b0};
    for (int i = 0; i < 10; i++) if (tbl[i].op == op) v = tbl[i];
    return v;
  endfunction

  // Drive tms/tdi, sample outputs after the falling edge, then let the rising edge act.
  task automatic tick(input logic tms, input logic tdi);
    tms_i = tms;
    td_i  = tdi;
    @(negedge tck_i);
    #1;
    s_tdo   = td_o;
    s_cap   = capture_dr_o;
    s_upd   = update_dr_o;
    s_shift = shift_dr_o;
    s_en    = pmu_en_o;
    s_ptdi  = pmu_tdi_o;
    s_scan  = scan_in_o;
    @(posedge tck_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b1;
    #2;
    check("rst selects", 64'(sels), 64'd0);
    check("rst dr strobes", 64'({shift_dr_o, update_dr_o, capture_dr_o}), 64'd0);
    check("rst td_o", 64'(td_o), 64'd0);
    check("rst pmu_en_o", 64'(pmu_en_o), 64'd0);
    check("rst pmu_tck_o", 64'(pmu_tck_o), 64'd0);
    check("rst pmu_rst_o", 64'(pmu_rst_o), 64'd1);
    @(posedge tck_i);
    #1;
    rst_ni = 1'b0;
    cur = lookup(5'b00010);
  endtask

  // From Test-Logic-Reset or Run-Test/Idle; ends in Run-Test/Idle.
  task automatic load_ir(input logic [4:0] op);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(i == 4, op[i]);
      check("ir capture shifted out", 64'(s_tdo), (i == 0) ? 64'd1 : 64'd0);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    cur = lookup(op);
    check("selects after update-ir", 64'(sels), 64'(cur.sel));
  endtask

  // From Test-Logic-Reset or Run-Test/Idle; ends in Run-Test/Idle.
  task automatic scan_dr(input int n, input logic [63:0] tdi, output logic [63:0] tdo_bits);
    logic q[$];
    logic exp;
    logic [5:0] sub;
    int   p0;
    tdo_bits = '0;
    q = {};
    if (cur.src == 0) for (int i = 0; i < 32; i++) q.push_back(idcode_ref[i]);
    else q.push_back(1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("capture_dr_o", 64'(s_cap), 64'd1);
    p0 = pulses;
    for (int i = 0; i < n; i++) begin
      sub = 6'($urandom);
      {memory_out_i, fifo_out_i, confreg_out_i, clk_byp_out_i, observ_out_i, pmu_tdo_i} = sub;
      case (cur.src)
        2: exp = sub[5];
        3: exp = sub[4];
        4: exp = sub[3];
        5: exp = sub[2];
        6: exp = sub[1];
        7: exp = sub[0];
        default: begin
          exp = q.pop_front();
          q.push_back(tdi[i]);
        end
      endcase
      tick(i == n - 1, tdi[i]);
      check("td_o in shift-dr", 64'(s_tdo), 64'(exp));
      check("shift/en/tdi/scan_in", 64'({s_shift, s_en, s_ptdi, s_scan}),
            64'({1'b1, cur.en, tdi[i], tdi[i]}));
      tdo_bits[i] = s_tdo;
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("update_dr_o", 64'(s_upd), 64'd1);
    check("pmu_tck_o pulses", 64'(pulses - p0), cur.sel[0] ? 64'(n) : 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_ni = 1'b0;
    tms_i = 1'b0;
    td_i = 1'b0;
    {memory_out_i, fifo_out_i, confreg_out_i, clk_byp_out_i, observ_out_i, pmu_tdo_i} = '0;
    idcode_ref = 32'h1000_0001;
    tbl[0] = '{5'b00010, 6'b000000, 0, 1'b0};
    tbl[1] = '{5'b00100, 6'b100000, 2, 1'b0};
    tbl[2] = '{5'b00101, 6'b010000, 3, 1'b0};
    tbl[3] = '{5'b00110, 6'b001000, 4, 1'b0};
    tbl[4] = '{5'b00111, 6'b000100, 5, 1'b0};
    tbl[5] = '{5'b01000, 6'b000010, 6, 1'b0};
    tbl[6] = '{5'b01001, 6'b000000, 1, 1'b0};
    tbl[7] = '{5'b11010, 6'b000001, 7, 1'b0};
    tbl[8] = '{5'b11011, 6'b000001, 7, 1'b1};
    tbl[9] = '{5'b11111, 6'b000000, 1, 1'b0};
    #1;
    do_reset();

    // IDCODE straight out of reset.
    scan_dr(32, 64'd0, r);
    check("idcode value", 64'(r[31:0]), 64'h1000_0001);

    // PMU with chip-select: 64 shifts of ones, then five TMS=1 back to reset.
    do_reset();
    load_ir(5'b11011);
    check("pmu_sel_o", 64'(pmu_sel_o), 64'd1);
    check("pmu_rst_o idle", 64'(pmu_rst_o), 64'd0);
    scan_dr(64, '1, r);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    check("pmu_rst_o in tlr", 64'(pmu_rst_o), 64'd1);

    // Bypass delays by one clock behind a captured 0.
    load_ir(5'b11111);
    scan_dr(9, 64'h0000_0000_0000_00A5, r);
    check("bypass stream", 64'(r[8:0]), 64'h14A);

    // Every opcode in the table.
    for (int i = 0; i < 10; i++) begin
      load_ir(tbl[i].op);
      scan_dr(12, {$urandom, $urandom}, r);
    end

    // Reset in the middle of Shift-IR aborts without touching the active IR.
    load_ir(5'b00101);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    do_reset();
    scan_dr(32, 64'd0, r);
    check("idcode after abort", 64'(r[31:0]), 64'h1000_0001);

    // Random opcodes and lengths, with occasional random TMS walks ended by five TMS=1.
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < int'($urandom_range(0, 12)); k++)
          tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
        check("tlr after 5 tms: pmu_rst_o", 64'(pmu_rst_o), 64'd1);
        check("tlr after 5 tms: selects", 64'(sels), 64'd0);
        cur = lookup(5'b00010);
        scan_dr(32, {$urandom, $urandom}, r);
      end
      load_ir(5'($urandom));
      scan_dr(int'($urandom_range(1, 40)), {$urandom, $urandom}, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
